// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic inter-stage pipeline register with a 2-entry skid buffer.
// It registers o_ready, supports synchronous flush, and zeroes the control field on bubbles.
// It also counts downstream transfers in a wrapping debug counter.
// Optional debug single-step hold is enabled by defining PIPE_SKID_HALT_EN (adds i_halt).
module pipe_skid_reg #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_CTRL = 8,
  parameter int unsigned NB_CNT  = 16
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_flush,
`ifdef PIPE_SKID_HALT_EN
  input  logic               i_halt,
`endif
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_CTRL-1:0] i_ctrl,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [1:0]         o_occupancy,
  output logic [NB_CNT-1:0]  o_xfer_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] main_data_q, main_data_d;
  logic [NB_CTRL-1:0] main_ctrl_q, main_ctrl_d;
  logic [NB_DATA-1:0] skid_data_q, skid_data_d;
  logic [NB_CTRL-1:0] skid_ctrl_q, skid_ctrl_d;
  logic               ready_q, ready_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;

  logic halt_c;
  logic valid_c;
  logic ready_c;
  logic in_fire_c;
  logic out_fire_c;

`ifdef PIPE_SKID_HALT_EN
  assign halt_c = i_halt;
`else
  assign halt_c = 1'b0;
`endif

  // Handshake qualifiers; a halt hides both sides of the handshake
  assign valid_c    = (state_q != ST_EMPTY) && !halt_c;
  assign ready_c    = ready_q && !halt_c;
  assign in_fire_c  = i_valid && ready_c;
  assign out_fire_c = valid_c && i_ready;

  assign o_ready      = ready_q;
  assign o_valid      = valid_c;
  assign o_data       = main_data_q;
  assign o_ctrl       = valid_c ? main_ctrl_q : NB_CTRL'(0);
  assign o_occupancy  = state_q;
  assign o_xfer_count = cnt_q;

  // State, storage, ready and counter registers
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and storage update; flush wins but a concurrent downstream transfer still counts
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    cnt_d       = cnt_q;

    if (out_fire_c) begin
      cnt_d = cnt_q + NB_CNT'(1);
    end

    if (i_flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire_c) begin
            state_d     = ST_ONE;
            main_data_d = i_data;
            main_ctrl_d = i_ctrl;
          end
        end
        ST_ONE: begin
          if (in_fire_c && !out_fire_c) begin
            state_d     = ST_FULL;
            skid_data_d = i_data;
            skid_ctrl_d = i_ctrl;
          end else if (in_fire_c && out_fire_c) begin
            main_data_d = i_data;
            main_ctrl_d = i_ctrl;
          end else if (out_fire_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire_c) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    ready_d = (state_d != ST_FULL);
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing fixed hold-on-step stage registers. It carries a data payload and a control field with a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered o_ready. It also provides synchronous flush, bubble-killing of control bits, and a wrapping transfer counter for debug.

Parameters:
NB_DATA, 32, width of data payload (e.g. ALU result + mem read concatenated by instantiator)
NB_CTRL, 8, width of control field (regWrite, mem2reg, dest reg, ...); forced to zero on bubbles
NB_CNT, 16, width of output transfer counter

Ports:
clk  input  1  clock, rising edge
i_reset  input  1  reset, asynchronous, active-low
i_flush  input  1  synchronous flush, drops all held entries
i_valid  input  1  upstream entry valid
o_ready  output  1  stage can accept (registered)
i_data  input  NB_DATA  upstream payload
i_ctrl  input  NB_CTRL  upstream control
o_valid  output  1  entry available downstream
i_ready  input  1  downstream accepts
o_data  output  NB_DATA  head payload
o_ctrl  output  NB_CTRL  head control, zero when o_valid=0
o_occupancy  output  2  entries held (0..2)
o_xfer_count  output  NB_CNT  number of downstream transfers, wraps

Behaviour:
- in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- Storage: main entry (head) and skid entry, each NB_DATA+NB_CTRL bits. State EMPTY/ONE/FULL encoded as o_occupancy 0/1/2.
- o_valid = (state != EMPTY), combinational from state.
- o_data = main data. o_ctrl = o_valid ? main ctrl : 0.
- o_ready is a flop. Next value = (next_state != FULL) and not in reset.
- Transitions, flush not asserted:
  - EMPTY: in_fire → ONE, main<=input.
  - ONE: in & !out → FULL, skid<=input.
  - ONE: in & out → ONE, main<=input.
  - ONE: !in & out → EMPTY.
  - ONE: neither → hold.
  - FULL: out_fire → ONE, main<=skid.
  - FULL: otherwise hold. in_fire cannot occur in FULL because o_ready=0.
- Latency: i_valid with o_ready=1 at edge N gives o_valid=1 after edge N. Min latency 1 cycle. Throughput 1/cycle with i_ready held high.
- Data stability: while o_valid=1 and i_ready=0, o_data and o_ctrl hold constant.
- i_flush=1 at an edge has highest priority:
  - state→EMPTY; o_ready→1; main and skid ctrl cleared to 0; data regs hold.
  - A simultaneous in_fire is discarded.
  - A simultaneous out_fire still completes downstream and counts in o_xfer_count.
- o_xfer_count increments on each out_fire and wraps from 2^NB_CNT−1 to 0. Not cleared by flush.
- Reset (i_reset=0, any time, asynchronous):
  - state=EMPTY, o_ready=0, all data/ctrl regs=0, o_xfer_count=0.
  - o_valid=0, o_ctrl=0, o_data=0, o_occupancy=0.
  - After release, o_ready rises at the first rising edge. No transfer occurs on that edge.
- Reset mid-operation: held entries are lost and no output is produced until new input.
- i_valid with o_ready=0 is not a transfer. Upstream must hold i_data and i_ctrl.

Optional Feature:
Macro PIPE_SKID_HALT_EN.

When defined:
- Adds input i_halt (1 bit), debug single-step hold.
- While i_halt=1, the internal o_ready and o_valid used for transfers are gated to 0. Output port o_valid reads 0 and o_ctrl reads 0. No state change, storage held, counter frozen.
- i_flush still overrides i_halt.
- On i_halt deassert, o_valid reflects held state in the same cycle and o_ready reflects the registered value.

When not defined: port absent, behaviour as above.

Test Plan:
- Reset release, i_valid=1, i_data=0x11, i_ready=1 → o_ready 0 until first edge; 0x11 appears on o_data the edge after o_ready=1; o_xfer_count=1.
- Stream 0x01..0x08 with i_valid=1, i_ready=1 → one output per cycle, in order, occupancy stays 1, o_xfer_count=8.
- Backpressure: send 0xA,0xB,0xC with i_ready=0 → occupancy 2 after 0xA,0xB; o_ready=0; 0xC held upstream; raise i_ready → outputs 0xA,0xB,0xC in order, no loss or duplication.
- Flush with occupancy 2 and i_ctrl=0xFF entries plus simultaneous i_valid → next cycle o_valid=0, o_ctrl=0x00, occupancy 0, o_ready=1, input dropped.
- NB_CNT=4, 17 transfers → o_xfer_count wraps to 1. Assert i_reset mid-stream → all outputs 0 immediately, without waiting for an edge.
- PIPE_SKID_HALT_EN: i_halt=1 with occupancy 1 → o_valid=0, counter frozen 3 cycles; release → same head data delivered exactly once.
